// File: rtl/iter_muldiv_unit.sv
// ----------------------------------------------------------------------------
// iter_muldiv_unit
//   Iterative RV32M multiply/divide unit. One MUL/MULH/MULHSU/MULHU/DIV/DIVU/
//   REM/REMU op at a time. A shift-add multiplier or a restoring divider runs
//   for WIDTH cycles on operand magnitudes. A FIX cycle then applies the
//   recorded signs and selects the result half.
//
// Ports
//   clk     in   1      rising-edge clock
//   rst     in   1      synchronous active-high reset
//   start   in   1      launch op (accepted only in IDLE)
//   flush   in   1      abort in-flight op, no done pulse, result untouched
//   funct3  in   3      RV32M op select
//   op_a    in   WIDTH  rs1 (multiplicand / dividend)
//   op_b    in   WIDTH  rs2 (multiplier / divisor)
//   busy    out  1      high in CALC and FIX
//   done    out  1      one-cycle pulse, result valid
//   result  out  WIDTH  registered result, holds until next done
// ----------------------------------------------------------------------------
module iter_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_funct3;
    logic               r_neg_q;   // product / quotient sign
    logic               r_neg_r;   // remainder sign (dividend sign)
    logic [WIDTH-1:0]   r_hi;      // product high half / partial remainder
    logic [WIDTH-1:0]   r_lo;      // multiplier -> product low / dividend -> quotient
    logic [WIDTH-1:0]   r_op;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_result;

    // Launch-time decode
    logic               w_a_signed, w_b_signed;
    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic               w_div_zero, w_ovf, w_special;
    logic [WIDTH-1:0]   w_special_val;

    // Iteration datapath
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;

    // Sign fix / select
    logic [2*WIDTH-1:0] w_prod_raw, w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem, w_fix;

    always_comb begin
        w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b110);
        w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                     (funct3 == 3'b110);
        w_a_neg    = w_a_signed && op_a[WIDTH-1];
        w_b_neg    = w_b_signed && op_b[WIDTH-1];
        w_a_mag    = w_a_neg ? -op_a : op_a;
        w_b_mag    = w_b_neg ? -op_b : op_b;

        w_div_zero = funct3[2] && (op_b == '0);
        // Signed overflow only for DIV/REM (funct3[0]==0 within the div group)
        w_ovf      = funct3[2] && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
        w_special  = w_div_zero || w_ovf;

        w_special_val = '0;
        if (w_div_zero)
            w_special_val = funct3[1] ? op_a : '1;
        else if (w_ovf)
            w_special_val = funct3[1] ? '0 : MIN_NEG;
    end

    always_comb begin
        // Shift-add: conditionally add multiplicand into the high half, the
        // carry-out becomes the top bit after the right shift.
        w_add     = {1'b0, r_hi} + {1'b0, r_op};
        w_mul_sum = r_lo[0] ? w_add : {1'b0, r_hi};

        // Restoring divide: bring the next dividend bit into the remainder.
        w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
        w_diff    = w_rem_sh - {1'b0, r_op};
    end

    always_comb begin
        w_prod_raw = {r_hi, r_lo};
        w_prod     = r_neg_q ? -w_prod_raw : w_prod_raw;
        w_quo      = r_neg_q ? -r_lo : r_lo;
        w_rem      = r_neg_r ? -r_hi : r_hi;

        if (r_funct3[2])
            w_fix = r_funct3[1] ? w_rem : w_quo;
        else if (r_funct3[1:0] == 2'b00)
            w_fix = w_prod[WIDTH-1:0];
        else
            w_fix = w_prod[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_funct3 <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_op     <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_funct3 <= funct3;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_hi     <= '0;
                        r_cnt    <= '0;
                        if (funct3[2]) begin
                            r_lo <= w_a_mag;
                            r_op <= w_b_mag;
                        end else begin
                            r_lo <= w_b_mag;
                            r_op <= w_a_mag;
                        end
                        if (w_special) begin
                            r_result <= w_special_val;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (r_funct3[2]) begin
                            if (!w_diff[WIDTH]) begin
                                r_hi <= w_diff[WIDTH-1:0];
                                r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                            end else begin
                                r_hi <= w_rem_sh[WIDTH-1:0];
                                r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            r_hi <= w_mul_sum[WIDTH:1];
                            r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(WIDTH-1))
                            r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_result <= w_fix;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = (r_state == S_CALC) || (r_state == S_FIX);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_iter_muldiv_unit
//   Self-checking bench for iter_muldiv_unit at WIDTH=32. Expected results are
//   pushed to a scoreboard queue at launch and popped when done pulses.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_iter_muldiv_unit;

    localparam int WIDTH = 32;
    localparam int LAT_N = WIDTH + 2;
    localparam int LAT_S = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              flush;
    logic [2:0]        funct3;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;

    logic [WIDTH-1:0]  exp_q[$];
    logic [WIDTH-1:0]  last_res;
    int                n_checks = 0;
    int                n_fail   = 0;

    iter_muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (f)
            3'd0: p = sa * sb;
            3'd1: p = sa * sb;
            3'd2: p = sa * ub;
            3'd3: p = ua * ub;
            3'd4: begin
                if (b == 0) p = '1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'b0, 32'h8000_0000};
                else p = sa / sb;
            end
            3'd5: p = (b == 0) ? '1 : ua / ub;
            3'd6: begin
                if (b == 0) p = {32'b0, a};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = '0;
                else p = sa % sb;
            end
            default: p = (b == 0) ? {32'b0, a} : ua % ub;
        endcase
        if (f == 3'd1 || f == 3'd2 || f == 3'd3) return p[63:32];
        return p[31:0];
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return LAT_S;
        return LAT_N;
    endfunction

    // Called on a falling edge; start is sampled on the next rising edge.
    // Inputs are scrambled afterwards: the captured op must not depend on them.
    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        exp_q.push_back(expv);
        @(negedge clk);
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
    endtask

    // Returns the cycle index (1 = cycle after start edge) at which done is
    // seen, or -1 on timeout, plus how many pre-done cycles had busy low.
    task automatic wait_done(output int lat, output int busy_low,
                             output logic busy_at_done, output logic [31:0] res);
        lat = -1;
        busy_low = 0;
        busy_at_done = 1'bx;
        res = 'x;
        for (int n = 1; n <= WIDTH + 20; n++) begin
            if (done === 1'b1) begin
                lat = n;
                busy_at_done = busy;
                res = result;
                break;
            end
            if (busy !== 1'b1) busy_low++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = '0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (result !== '0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
        rst = 1'b0;
        last_res = '0;
        @(negedge clk);
    endtask

    task automatic test_mul();
        logic [2:0]  tf[4] = '{3'd0, 3'd1, 3'd3, 3'd2};
        logic [31:0] ta[4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] tb[4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] te[4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        int lat, bl; logic bd; logic [31:0] res, expv;
        for (int i = 0; i < 4; i++) begin
            launch(tf[i], ta[i], tb[i], te[i]);
            wait_done(lat, bl, bd, res);
            expv = exp_q.pop_front();
            n_checks++; if (lat !== LAT_N) begin n_fail++; $display("FAIL mul[%0d]_latency got %0d want %0d", i, lat, LAT_N); end
            n_checks++; if (bl !== 0 || bd !== 1'b0) begin n_fail++; $display("FAIL mul[%0d]_busy low_cycles=%0d busy_at_done=%b want 0/0", i, bl, bd); end
            n_checks++; if (res !== expv) begin n_fail++; $display("FAIL mul[%0d]_result got %h want %h", i, res, expv); end
            last_res = expv;
            @(negedge clk);
        end
    endtask

    task automatic test_div();
        logic [2:0]  tf[8] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] ta[8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                               32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] tb[8] = '{32'd2, 32'd2, 32'd7, 32'd7,
                               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] te[8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                               32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        int          tl[8] = '{LAT_N, LAT_N, LAT_N, LAT_N, LAT_S, LAT_S, LAT_S, LAT_S};
        int lat, bl; logic bd; logic [31:0] res, expv;
        for (int i = 0; i < 8; i++) begin
            launch(tf[i], ta[i], tb[i], te[i]);
            wait_done(lat, bl, bd, res);
            expv = exp_q.pop_front();
            n_checks++; if (lat !== tl[i]) begin n_fail++; $display("FAIL div[%0d]_latency got %0d want %0d", i, lat, tl[i]); end
            n_checks++; if (bl !== 0 || bd !== 1'b0) begin n_fail++; $display("FAIL div[%0d]_busy low_cycles=%0d busy_at_done=%b want 0/0", i, bl, bd); end
            n_checks++; if (res !== expv) begin n_fail++; $display("FAIL div[%0d]_result got %h want %h", i, res, expv); end
            last_res = expv;
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int lat, bl, el; logic bd; logic [2:0] f; logic [31:0] a, b, res, expv;
        for (int i = 0; i < 24; i++) begin
            f = 3'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                3: b = -32'($urandom_range(1, 9));
                default: ;
            endcase
            el = exp_lat(f, a, b);
            launch(f, a, b, model(f, a, b));
            wait_done(lat, bl, bd, res);
            expv = exp_q.pop_front();
            n_checks++; if (lat !== el) begin n_fail++; $display("FAIL rnd[%0d]_latency f=%0d a=%h b=%h got %0d want %0d", i, f, a, b, lat, el); end
            n_checks++; if (res !== expv) begin n_fail++; $display("FAIL rnd[%0d]_result f=%0d a=%h b=%h got %h want %h", i, f, a, b, res, expv); end
            last_res = expv;
            @(negedge clk);
        end
    endtask

    task automatic test_flush();
        int lat, bl, dseen; logic bd; logic [31:0] res, expv;
        // Flush DIV at cycle t+10
        launch(3'd4, 32'd1000, 32'd3, 32'd0);
        void'(exp_q.pop_back());
        dseen = 0;
        for (int n = 1; n < 10; n++) begin
            if (done === 1'b1) dseen++;
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0 || dseen != 0) begin n_fail++; $display("FAIL flush_done got %b early_pulses=%0d want 0/0", done, dseen); end
        n_checks++; if (result !== last_res) begin n_fail++; $display("FAIL flush_result got %h want %h", result, last_res); end
        // New start in cycle t+11
        launch(3'd5, 32'd1000, 32'd3, 32'd333);
        wait_done(lat, bl, bd, res);
        expv = exp_q.pop_front();
        n_checks++; if (lat !== LAT_N) begin n_fail++; $display("FAIL flush_restart_latency got %0d want %0d", lat, LAT_N); end
        n_checks++; if (res !== expv) begin n_fail++; $display("FAIL flush_restart_result got %h want %h", res, expv); end
        last_res = expv;
        @(negedge clk);
        // flush together with start in IDLE: op dropped
        funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3;
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        dseen = 0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy got %b want 0", busy); end
        for (int n = 0; n < 4; n++) begin
            if (done === 1'b1 || busy === 1'b1) dseen++;
            @(negedge clk);
        end
        n_checks++; if (dseen != 0 || result !== last_res) begin n_fail++; $display("FAIL flush_start_dropped activity=%0d result=%h want 0/%h", dseen, result, last_res); end
    endtask

    task automatic test_ignore_and_rst();
        int lat, bl; logic bd; logic [31:0] res, expv;
        // start while busy is ignored
        launch(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        repeat (2) @(negedge clk);
        funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy got %b want 1", busy); end
        wait_done(lat, bl, bd, res);
        expv = exp_q.pop_front();
        n_checks++; if (res !== expv || lat < 0) begin n_fail++; $display("FAIL ignore_result got %h (lat %0d) want %h", res, lat, expv); end
        last_res = expv;
        @(negedge clk);
        // rst in the middle of CALC
        launch(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);
        void'(exp_q.pop_back());
        repeat (5) @(negedge clk);
        rst = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got %b want 0", done); end
        n_checks++; if (result !== '0) begin n_fail++; $display("FAIL rst_mid_result got %h want 0", result); end
        last_res = '0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, bl; logic bd; logic [31:0] res, expv;
        launch(3'd5, 32'd100, 32'd7, 32'd14);
        wait_done(lat, bl, bd, res);
        expv = exp_q.pop_front();
        n_checks++; if (res !== expv) begin n_fail++; $display("FAIL b2b_first_result got %h want %h", res, expv); end
        last_res = expv;
        // start during the DONE cycle must be dropped
        funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_start busy=%b done=%b want 0/0", busy, done); end
        launch(3'd0, 32'd3, 32'd5, 32'd15);
        wait_done(lat, bl, bd, res);
        expv = exp_q.pop_front();
        n_checks++; if (lat !== LAT_N) begin n_fail++; $display("FAIL b2b_second_latency got %0d want %0d", lat, LAT_N); end
        n_checks++; if (res !== expv) begin n_fail++; $display("FAIL b2b_second_result got %h want %h", res, expv); end
        last_res = expv;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_random();
        test_flush();
        test_ignore_and_rst();
        test_back_to_back();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
